ikaopm_timer_bus_if: RTL and testbench

CPU-side writer/reader for the timer block. It decodes YM2151-style bus cycles: A0=0 selects the address register, A0=1 writes data to the selected register. It drives all timer control inputs (CLKA1/CLKA2/CLKB, run, IRQ enable, flag reset, TEST_D2) and returns the status byte built from the timer flags plus a write-busy bit. It sits between the external bus pins and the timer block, in the phi1 emulation-enable domain.

---
 rtl/ikaopm_timer_bus_if_pkg.sv | 46 ++++
 rtl/ikaopm_timer_bus_if_bus_sync.sv | 58 +++++
 rtl/ikaopm_timer_bus_if.sv | 152 +++++++++++++++
 tb/tb_ikaopm_timer_bus_if.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ikaopm_timer_bus_if_pkg.sv
// Shared constants for the OPM timer bus interface: register map, timer-control
// bit positions and status-byte layout.
package ikaopm_timer_bus_if_pkg;

    localparam logic [7:0] REG_TEST  = 8'h01;
    localparam logic [7:0] REG_CLKA1 = 8'h10;
    localparam logic [7:0] REG_CLKA2 = 8'h11;
    localparam logic [7:0] REG_CLKB  = 8'h12;
    localparam logic [7:0] REG_TCTRL = 8'h14;

    localparam int TEST_D2_BIT = 2;

    localparam int TC_RUN_A  = 0;
    localparam int TC_RUN_B  = 1;
    localparam int TC_IRQ_A  = 2;
    localparam int TC_IRQ_B  = 3;
    localparam int TC_FRST_A = 4;
    localparam int TC_FRST_B = 5;
    localparam int TC_CSM    = 7;

    localparam int ST_FLAG_A = 0;
    localparam int ST_FLAG_B = 1;
    localparam int ST_BUSY   = 7;

    // One committed bus write, valid for a single EMUCLK cycle.
    typedef struct packed {
        logic       valid;
        logic       a0;
        logic [7:0] data;
    } bus_wr_t;

    function automatic logic is_mapped(input logic [7:0] addr);
        return addr inside {REG_TEST, REG_CLKA1, REG_CLKA2, REG_CLKB, REG_TCTRL};
    endfunction

    function automatic logic [7:0] status_byte(input logic busy, input logic flag_b,
                                               input logic flag_a);
        logic [7:0] s;
        s            = '0;
        s[ST_BUSY]   = busy;
        s[ST_FLAG_B] = flag_b;
        s[ST_FLAG_A] = flag_a;
        return s;
    endfunction

endpackage

// File: rtl/ikaopm_timer_bus_if_bus_sync.sv
// Registers the CPU bus strobes and turns each completed CS-qualified write
// strobe into a one-cycle commit carrying the data and A0 seen while WR_n was low.
module ikaopm_bus_sync
    import ikaopm_timer_bus_if_pkg::*;
(
    input  logic       i_EMUCLK,
    input  logic       i_MRST_n,
    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_RD_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    output bus_wr_t    o_wr,
    output logic       o_rd_any,
    output logic       o_rd_req
);

    logic       cs_n_q;
    logic       wr_n_q;
    logic       rd_n_q;
    logic       a0_q;
    logic       wr_hit;
    logic       a0_lat;
    logic [7:0] d_lat;

    // NOTE: non-blocking assignments keep wr_n_q at its pre-edge value when the
    // commit term is evaluated, which is what makes the 0->1 detection work.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            cs_n_q <= 1'b1;
            wr_n_q <= 1'b1;
            rd_n_q <= 1'b1;
            a0_q   <= 1'b0;
            wr_hit <= 1'b0;
            a0_lat <= 1'b0;
            d_lat  <= 8'h00;
            o_wr   <= '0;
        end else begin
            cs_n_q <= i_CS_n;
            wr_n_q <= i_WR_n;
            rd_n_q <= i_RD_n;
            a0_q   <= i_A0;
            if (!i_WR_n) begin
                wr_hit <= ~i_CS_n;
                a0_lat <= i_A0;
                d_lat  <= i_D;
            end
            o_wr.valid <= ~wr_n_q & i_WR_n & wr_hit;
            o_wr.a0    <= a0_lat;
            o_wr.data  <= d_lat;
        end
    end

    // A write strobe in progress masks the read.
    assign o_rd_any = ~cs_n_q & ~rd_n_q & wr_n_q;
    assign o_rd_req = o_rd_any & a0_q;

endmodule

// File: rtl/ikaopm_timer_bus_if.sv
// CPU-side register writer and status reader for the OPM timer block; data
// writes are applied on phi1 ticks and hold off the busy bit afterwards.
module ikaopm_timer_bus_if
    import ikaopm_timer_bus_if_pkg::*;
#(
    parameter int BUSY_CYCLES = 64
) (
    input  logic       i_EMUCLK,
    input  logic       i_MRST_n,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_RD_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    output logic [7:0] o_D,
    output logic       o_D_OE,
    input  logic       i_TIMERA_FLAG,
    input  logic       i_TIMERB_FLAG,
    output logic [7:0] o_CLKA1,
    output logic [1:0] o_CLKA2,
    output logic [7:0] o_CLKB,
    output logic       o_TIMERA_RUN,
    output logic       o_TIMERB_RUN,
    output logic       o_TIMERA_IRQ_EN,
    output logic       o_TIMERB_IRQ_EN,
    output logic       o_TIMERA_FRST,
    output logic       o_TIMERB_FRST,
    output logic       o_CSM_EN,
    output logic       o_TEST_D2,
    output logic       o_BUSY
);

    bus_wr_t    bus_wr;
    logic       rd_any;
    logic       rd_req;

    logic       phi1_tick;
    logic       data_commit;
    logic       apply;
    logic       apply_tctrl;
    logic       pending;
    logic [7:0] addr_q;
    logic [7:0] hold_addr;
    logic [7:0] hold_data;
    logic [7:0] busy_cnt;

    ikaopm_bus_sync u_bus_sync (
        .i_EMUCLK (i_EMUCLK),
        .i_MRST_n (i_MRST_n),
        .i_CS_n   (i_CS_n),
        .i_WR_n   (i_WR_n),
        .i_RD_n   (i_RD_n),
        .i_A0     (i_A0),
        .i_D      (i_D),
        .o_wr     (bus_wr),
        .o_rd_any (rd_any),
        .o_rd_req (rd_req)
    );

    assign phi1_tick   = ~i_phi1_NCEN_n;
    assign data_commit = bus_wr.valid & bus_wr.a0 & is_mapped(addr_q);
    assign apply       = pending & phi1_tick;
    assign apply_tctrl = apply & (hold_addr == REG_TCTRL);
    assign o_BUSY      = (busy_cnt != 8'd0) | pending;

    // NOTE: the async reset also clears the holder and pending flag, so a write
    // caught by reset is dropped instead of being applied after release.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            addr_q    <= 8'h00;
            hold_addr <= 8'h00;
            hold_data <= 8'h00;
            pending   <= 1'b0;
        end else begin
            if (bus_wr.valid && !bus_wr.a0) begin
                addr_q <= bus_wr.data;
            end
            // A commit landing on a tick re-arms pending, so it waits for the next tick.
            if (data_commit) begin
                hold_addr <= addr_q;
                hold_data <= bus_wr.data;
                pending   <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            o_CLKA1         <= 8'h00;
            o_CLKA2         <= 2'b00;
            o_CLKB          <= 8'h00;
            o_TIMERA_RUN    <= 1'b0;
            o_TIMERB_RUN    <= 1'b0;
            o_TIMERA_IRQ_EN <= 1'b0;
            o_TIMERB_IRQ_EN <= 1'b0;
            o_CSM_EN        <= 1'b0;
            o_TEST_D2       <= 1'b0;
        end else if (apply) begin
            case (hold_addr)
                REG_TEST:  o_TEST_D2 <= hold_data[TEST_D2_BIT];
                REG_CLKA1: o_CLKA1   <= hold_data;
                REG_CLKA2: o_CLKA2   <= hold_data[1:0];
                REG_CLKB:  o_CLKB    <= hold_data;
                REG_TCTRL: begin
                    o_TIMERA_RUN    <= hold_data[TC_RUN_A];
                    o_TIMERB_RUN    <= hold_data[TC_RUN_B];
                    o_TIMERA_IRQ_EN <= hold_data[TC_IRQ_A];
                    o_TIMERB_IRQ_EN <= hold_data[TC_IRQ_B];
                    o_CSM_EN        <= hold_data[TC_CSM];
                end
                default: ;
            endcase
        end
    end

    // Flag-reset pulses span from the applying tick up to and including the next tick.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            o_TIMERA_FRST <= 1'b0;
            o_TIMERB_FRST <= 1'b0;
        end else if (phi1_tick) begin
            o_TIMERA_FRST <= apply_tctrl & hold_data[TC_FRST_A];
            o_TIMERB_FRST <= apply_tctrl & hold_data[TC_FRST_B];
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            busy_cnt <= 8'd0;
        end else if (apply) begin
            busy_cnt <= 8'(BUSY_CYCLES);
        end else if (phi1_tick && busy_cnt != 8'd0) begin
            busy_cnt <= busy_cnt - 8'd1;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            o_D    <= 8'h00;
            o_D_OE <= 1'b0;
        end else begin
            o_D_OE <= rd_req;
            if (rd_any) begin
                o_D <= status_byte(o_BUSY, i_TIMERB_FLAG, i_TIMERA_FLAG);
            end
        end
    end

endmodule

// File: tb/tb_ikaopm_timer_bus_if.sv
// Directed and randomized bench for ikaopm_timer_bus_if against a register-map
// model; busy and flag-reset timing are measured in phi1 ticks.
module tb_ikaopm_timer_bus_if;

    localparam int PHI  = 4;
    localparam int BUSY = 64;

    logic       i_EMUCLK      = 1'b0;
    logic       i_MRST_n      = 1'b1;
    logic       i_phi1_NCEN_n = 1'b1;
    logic       i_CS_n        = 1'b1;
    logic       i_WR_n        = 1'b1;
    logic       i_RD_n        = 1'b1;
    logic       i_A0          = 1'b0;
    logic [7:0] i_D           = 8'h00;
    logic       i_TIMERA_FLAG = 1'b0;
    logic       i_TIMERB_FLAG = 1'b0;
    logic [7:0] o_D;
    logic       o_D_OE;
    logic [7:0] o_CLKA1;
    logic [1:0] o_CLKA2;
    logic [7:0] o_CLKB;
    logic       o_TIMERA_RUN, o_TIMERB_RUN;
    logic       o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN;
    logic       o_TIMERA_FRST, o_TIMERB_FRST;
    logic       o_CSM_EN, o_TEST_D2, o_BUSY;

    int          checks   = 0;
    int          failures = 0;
    int unsigned tick_cnt = 0;
    bit          phi_en   = 1'b0;
    logic [7:0]  m_regs [256];

    ikaopm_timer_bus_if #(.BUSY_CYCLES(BUSY)) dut (
        .i_EMUCLK        (i_EMUCLK),
        .i_MRST_n        (i_MRST_n),
        .i_phi1_NCEN_n   (i_phi1_NCEN_n),
        .i_CS_n          (i_CS_n),
        .i_WR_n          (i_WR_n),
        .i_RD_n          (i_RD_n),
        .i_A0            (i_A0),
        .i_D             (i_D),
        .o_D             (o_D),
        .o_D_OE          (o_D_OE),
        .i_TIMERA_FLAG   (i_TIMERA_FLAG),
        .i_TIMERB_FLAG   (i_TIMERB_FLAG),
        .o_CLKA1         (o_CLKA1),
        .o_CLKA2         (o_CLKA2),
        .o_CLKB          (o_CLKB),
        .o_TIMERA_RUN    (o_TIMERA_RUN),
        .o_TIMERB_RUN    (o_TIMERB_RUN),
        .o_TIMERA_IRQ_EN (o_TIMERA_IRQ_EN),
        .o_TIMERB_IRQ_EN (o_TIMERB_IRQ_EN),
        .o_TIMERA_FRST   (o_TIMERA_FRST),
        .o_TIMERB_FRST   (o_TIMERB_FRST),
        .o_CSM_EN        (o_CSM_EN),
        .o_TEST_D2       (o_TEST_D2),
        .o_BUSY          (o_BUSY)
    );

    initial forever #5 i_EMUCLK = ~i_EMUCLK;

    // phi1 enable: one EMUCLK cycle low out of every PHI while phi_en is set.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge i_EMUCLK);
            if (phi_en) begin
                ph = (ph + 1) % PHI;
                i_phi1_NCEN_n = (ph != 0);
            end else begin
                i_phi1_NCEN_n = 1'b1;
            end
        end
    end

    initial forever begin
        @(posedge i_EMUCLK);
        if (!i_phi1_NCEN_n) tick_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_mapped(input logic [7:0] a);
        return a == 8'h01 || a == 8'h10 || a == 8'h11 || a == 8'h12 || a == 8'h14;
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 8'h00;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [7:0] v);
        if (model_mapped(a)) m_regs[a] = v;
    endtask

    function automatic logic [7:0] obs_reg(input logic [7:0] a);
        case (a)
            8'h10:   return o_CLKA1;
            8'h11:   return {6'b0, o_CLKA2};
            default: return o_CLKB;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".clka1"}, o_CLKA1, m_regs[8'h10]);
        check({tag, ".clka2"}, o_CLKA2, m_regs[8'h11] & 8'h03);
        check({tag, ".clkb"},  o_CLKB,  m_regs[8'h12]);
        check({tag, ".run_a"}, o_TIMERA_RUN, m_regs[8'h14] & 8'h01);
        check({tag, ".run_b"}, o_TIMERB_RUN, (m_regs[8'h14] >> 1) & 8'h01);
        check({tag, ".irq_a"}, o_TIMERA_IRQ_EN, (m_regs[8'h14] >> 2) & 8'h01);
        check({tag, ".irq_b"}, o_TIMERB_IRQ_EN, (m_regs[8'h14] >> 3) & 8'h01);
        check({tag, ".csm"},   o_CSM_EN, (m_regs[8'h14] >> 7) & 8'h01);
        check({tag, ".test"},  o_TEST_D2, (m_regs[8'h01] >> 2) & 8'h01);
    endtask

    task automatic check_zero(input string tag);
        check_regs(tag);
        check({tag, ".d"},      o_D, 0);
        check({tag, ".oe"},     o_D_OE, 0);
        check({tag, ".busy"},   o_BUSY, 0);
        check({tag, ".frst_a"}, o_TIMERA_FRST, 0);
        check({tag, ".frst_b"}, o_TIMERB_FRST, 0);
    endtask

    task automatic bus_write(input logic a0, input logic [7:0] v);
        @(negedge i_EMUCLK);
        i_CS_n = 1'b0; i_WR_n = 1'b0; i_A0 = a0; i_D = v;
        @(negedge i_EMUCLK);
        i_CS_n = 1'b1; i_WR_n = 1'b1;
        @(negedge i_EMUCLK);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] v);
        bus_write(1'b0, a);
        bus_write(1'b1, v);
        model_write(a, v);
    endtask

    task automatic do_read(input string tag, input logic [7:0] exp);
        @(negedge i_EMUCLK);
        i_CS_n = 1'b0; i_RD_n = 1'b0; i_A0 = 1'b1;
        @(posedge i_EMUCLK); @(posedge i_EMUCLK); #1;
        check({tag, ".oe"}, o_D_OE, 1);
        check({tag, ".d"},  o_D, exp);
        @(negedge i_EMUCLK);
        i_CS_n = 1'b1; i_RD_n = 1'b1;
        @(posedge i_EMUCLK); @(posedge i_EMUCLK); #1;
        check({tag, ".oe_off"}, o_D_OE, 0);
        check({tag, ".d_hold"}, o_D, exp);
    endtask

    // Called right after a data write; returns the tick count at the applying edge.
    task automatic wait_apply(input string tag, input logic [7:0] a, input logic [7:0] v,
                              output int unsigned t_apply);
        bit hit;
        hit = 1'b0;
        @(posedge i_EMUCLK); #1;
        check({tag, ".busy_now"}, o_BUSY, 1);
        for (int i = 0; i < PHI + 1 && !hit; i++) begin
            @(posedge i_EMUCLK); #1;
            if (obs_reg(a) == v) hit = 1'b1;
        end
        t_apply = tick_cnt;
        check({tag, ".latency"}, obs_reg(a), v);
    endtask

    task automatic measure_busy(input string tag, input int unsigned t_apply);
        for (int i = 0; i < (BUSY + 4) * PHI && o_BUSY; i++) begin
            @(posedge i_EMUCLK); #1;
        end
        check({tag, ".busy_ticks"}, tick_cnt - t_apply, BUSY);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < (BUSY + 4) * PHI && o_BUSY; i++) begin
            @(posedge i_EMUCLK); #1;
        end
        check({tag, ".idle"}, o_BUSY, 0);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge i_EMUCLK); while (i_phi1_NCEN_n);
        end
        #1;
    endtask

    initial begin
        int unsigned t1, t2;
        int hi;
        model_reset();

        #2 i_MRST_n = 1'b0;
        #1 check_zero("reset_async");
        repeat (3) @(negedge i_EMUCLK);
        check_zero("reset_hold");
        i_MRST_n = 1'b1;
        phi_en = 1'b1;
        repeat (4) @(negedge i_EMUCLK);
        check_zero("after_release");

        // CLKA1 write, exact busy length
        write_reg(8'h10, 8'hA5);
        wait_apply("clka1", 8'h10, 8'hA5, t1);
        measure_busy("clka1", t1);

        write_reg(8'h11, 8'h03);
        wait_apply("clka2", 8'h11, 8'h03, t1);
        write_reg(8'h12, 8'h7F);
        wait_apply("clkb", 8'h12, 8'h7F, t1);
        check_regs("regs1");
        wait_idle("regs1");

        // Unmapped address: nothing changes, no busy
        write_reg(8'h13, 8'hC9);
        repeat (PHI + 4) @(posedge i_EMUCLK);
        #1;
        check_regs("unmapped");
        check("unmapped.busy", o_BUSY, 0);

        // Timer control with both flag resets
        write_reg(8'h14, 8'h3F);
        @(posedge i_EMUCLK); #1;
        for (int i = 0; i < PHI + 1 && !o_TIMERA_FRST; i++) begin
            @(posedge i_EMUCLK); #1;
        end
        check("frst.a_start", o_TIMERA_FRST, 1);
        check("frst.b_start", o_TIMERB_FRST, 1);
        hi = 1;
        for (int i = 0; i < 4 * PHI && o_TIMERA_FRST; i++) begin
            @(posedge i_EMUCLK); #1;
            if (o_TIMERA_FRST) hi++;
        end
        check("frst.width", hi, PHI);
        check("frst.b_end", o_TIMERB_FRST, 0);
        check_regs("tctrl");
        wait_idle("tctrl");

        // Status byte while busy and after busy expires
        write_reg(8'h10, 8'h3C);
        wait_apply("status_wr", 8'h10, 8'h3C, t1);
        wait_ticks(10);
        i_TIMERA_FLAG = 1'b1;
        i_TIMERB_FLAG = 1'b0;
        do_read("status_busy", 8'h81);
        wait_idle("status");
        do_read("status_idle", 8'h01);

        // Rewrite with 20 ticks of busy left: counter reloads to full length
        write_reg(8'h12, 8'h33);
        wait_apply("reload1", 8'h12, 8'h33, t1);
        wait_ticks(BUSY - 20);
        check("reload.still_busy", o_BUSY, 1);
        bus_write(1'b1, 8'h44);
        model_write(8'h12, 8'h44);
        wait_apply("reload2", 8'h12, 8'h44, t2);
        measure_busy("reload2", t2);

        // Write and read strobes together: write wins, read suppressed
        bus_write(1'b0, 8'h10);
        @(negedge i_EMUCLK);
        i_CS_n = 1'b0; i_WR_n = 1'b0; i_RD_n = 1'b0; i_A0 = 1'b1; i_D = 8'h5A;
        @(posedge i_EMUCLK); @(posedge i_EMUCLK); #1;
        check("rdwr.oe_during", o_D_OE, 0);
        @(negedge i_EMUCLK);
        i_CS_n = 1'b1; i_WR_n = 1'b1; i_RD_n = 1'b1;
        @(posedge i_EMUCLK); @(posedge i_EMUCLK); #1;
        check("rdwr.oe_after", o_D_OE, 0);
        model_write(8'h10, 8'h5A);
        repeat (PHI + 4) @(posedge i_EMUCLK);
        #1;
        check_regs("rdwr");
        wait_idle("rdwr");

        // Randomized register writes and status reads
        for (int it = 0; it < 12; it++) begin
            logic [7:0] a, v;
            logic       fa, fb;
            case ($urandom_range(0, 6))
                0:       a = 8'h01;
                1:       a = 8'h10;
                2:       a = 8'h11;
                3:       a = 8'h12;
                4:       a = 8'h13;
                5:       a = 8'h14;
                default: a = 8'($urandom);
            endcase
            v = 8'($urandom);
            write_reg(a, v);
            repeat (PHI + 4) @(posedge i_EMUCLK);
            #1;
            check_regs("rand");
            fa = 1'($urandom_range(0, 1));
            fb = 1'($urandom_range(0, 1));
            i_TIMERA_FLAG = fa;
            i_TIMERB_FLAG = fb;
            do_read("rand_rd_busy", (model_mapped(a) ? 8'h80 : 8'h00) | (8'(fb) << 1) | 8'(fa));
            wait_idle("rand");
            check("rand.frst_a", o_TIMERA_FRST, 0);
            check("rand.frst_b", o_TIMERB_FRST, 0);
            fa = 1'($urandom_range(0, 1));
            i_TIMERA_FLAG = fa;
            do_read("rand_rd_idle", (8'(fb) << 1) | 8'(fa));
        end

        // Reset while a data write is still pending
        phi_en = 1'b0;
        repeat (2) @(negedge i_EMUCLK);
        bus_write(1'b0, 8'h12);
        bus_write(1'b1, 8'h55);
        @(posedge i_EMUCLK); #1;
        check("rst.pending_busy", o_BUSY, 1);
        @(negedge i_EMUCLK);
        i_MRST_n = 1'b0;
        model_reset();
        #1 check_zero("rst_pending");
        @(negedge i_EMUCLK);
        i_MRST_n = 1'b1;
        phi_en = 1'b1;
        repeat (3 * PHI) @(posedge i_EMUCLK);
        #1;
        check_zero("rst_no_stale");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
